// File: rtl/rr_grant_controller.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_controller
// Description : Sequential half of a round-robin arbiter. Chooses between the
//               masked and unmasked priority-arbiter grants, registers the
//               winner for its tenure, and rotates the priority mask so the
//               next search starts just above the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_controller #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16,
  localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH-1:0]   request_i,
  input  logic [WIDTH-1:0]   masked_grant_i,
  input  logic [WIDTH-1:0]   unmasked_grant_i,
  input  logic               done_i,
  output logic [WIDTH-1:0]   masked_request_o,
  output logic [WIDTH-1:0]   grant_o,
  output logic               grant_valid_o,
  output logic [c_IDX_W-1:0] grant_index_o
);

  // Tenure counter must be able to hold MAX_HOLD itself; one bit minimum.
  localparam int c_HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [c_HC_W-1:0] c_HOLD_LIMIT = c_HC_W'(MAX_HOLD);
  localparam logic [c_HC_W-1:0] c_HOLD_SAT   = {c_HC_W{1'b1}};
  localparam logic [c_HC_W-1:0] c_HOLD_ONE   = c_HC_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [c_IDX_W-1:0]   grant_index_q, grant_index_d;
  logic [c_HC_W-1:0]    hold_count_q, hold_count_d;
  logic [WIDTH-1:0]     mask_q, mask_d;

  logic [WIDTH-1:0]     w_masked_request;
  logic [WIDTH-1:0]     w_next_grant;
  logic [WIDTH-1:0]     w_mask_after;
  logic [c_IDX_W-1:0]   w_next_index;
  logic                 w_seen;
  logic                 w_hold_expired;
  logic                 w_release;

  // Masked request feeds the external masked priority arbiter.
  assign w_masked_request = request_i & mask_q;
  assign masked_request_o = w_masked_request;

  // Prefer a winner above the last owner; otherwise wrap to the raw search.
  assign w_next_grant = (|w_masked_request) ? masked_grant_i : unmasked_grant_i;

  // Build the rotated mask (bits strictly above the winner) and the winner index.
  always_comb begin
    w_seen       = 1'b0;
    w_mask_after = '0;
    w_next_index = '0;
    for (int j = 0; j < WIDTH; j++) begin
      w_mask_after[j] = w_seen;
      w_seen          = w_seen | w_next_grant[j];
      if (w_next_grant[j]) begin
        w_next_index = w_next_index | c_IDX_W'(j);
      end
    end
  end

  // Release on explicit done, owner withdrawal, or tenure exhaustion; any
  // combination of these is a single release.
  assign w_hold_expired = (MAX_HOLD != 0) && (hold_count_q == c_HOLD_LIMIT);
  assign w_release      = done_i | ~request_i[grant_index_q] | w_hold_expired;

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    hold_count_d  = hold_count_q;
    mask_d        = mask_q;
    case (state_q)
      S_IDLE: begin
        if (|request_i) begin
          grant_d       = w_next_grant;
          grant_valid_d = 1'b1;
          grant_index_d = w_next_index;
          hold_count_d  = c_HOLD_ONE;
          mask_d        = w_mask_after;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_index_d = '0;
          hold_count_d  = '0;
          state_d       = S_IDLE;
        end else if (hold_count_q != c_HOLD_SAT) begin
          hold_count_d  = hold_count_q + c_HOLD_ONE;
        end
      end
      default: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_index_d = '0;
        hold_count_d  = '0;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset opens the mask fully.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      hold_count_q  <= '0;
      mask_q        <= '1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      hold_count_q  <= hold_count_d;
      mask_q        <= mask_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_index_o = grant_index_q;

endmodule
`default_nettype wire
